punch_anim_ctrl: RTL and testbench
==================================

# punch_anim_ctrl

Sequencer for the punch character sprite. It accepts scored hit events from the rhythm judge, steps the sprite through an idle/windup/strike/recover animation paced by video frame ticks, and generates per-pixel sprite ROM addresses. It converts returned 4-bit colour indices into a pipelined palette index stream for the punch palette lookup, including a full-bright flash override on perfect hits. It sits between the judge, the sprite ROM and `punch_palette` in the VGA pixel path.

## Interface
- `WINDUP_TICKS`, 4, frame ticks spent in WINDUP (≥1)
- `STRIKE_TICKS`, 6, frame ticks spent in STRIKE (≥1)
- `RECOVER_TICKS`, 4, frame ticks spent in RECOVER (≥1)
- `FLASH_TICKS`, 3, frame ticks of flash override after a perfect hit (≥1)
- `FLASH_INDEX`, 4'hD, palette index substituted during flash
- `Clk  in  1`  system/pixel clock; the only clock
- `Reset  in  1`  synchronous, active-high reset
- `frame_tick  in  1`  one-cycle pulse at start of vertical blank
- `hit_valid  in  1`  judge presents a hit event
- `hit_grade  in  2`  0 miss, 1 good, 2 great, 3 perfect
- `hit_ready  out  1`  controller can accept a hit
- `drawX`, `drawY`  in  10  current pixel coordinate
- `sprite_x`, `sprite_y`  in  10  sprite top-left corner
- `rom_addr  out  14`  {disp_frame[1:0], row[5:0], col[5:0]} to sprite ROM
- `rom_data  in  4`  ROM colour index, valid one cycle after `rom_addr`
- `pal_index  out  4`  index to `punch_palette`
- `pix_active  out  1`  sprite pixel is opaque at this position
- `anim_state  out  2`  0 IDLE, 1 WINDUP, 2 STRIKE, 3 RECOVER
- `busy  out  1`  `anim_state != IDLE`

## Operation
- Accept: a hit is accepted when `hit_valid & hit_ready`. `hit_ready = (anim_state==IDLE) & ~Reset`. Hits are not queued; the judge holds `hit_valid` until accepted.
- Grade 0 is accepted and has no effect. FSM stays IDLE.
- Grade 1–3: IDLE→WINDUP on the cycle after acceptance. Tick counter is cleared.
- Grade 3 also loads `flash_cnt = FLASH_TICKS`.
- Tick counter: cleared on every state entry and incremented on each `frame_tick`.
  - `frame_tick` with `cnt == N-1`: advance to the next state and clear `cnt`.
  - Sequence: WINDUP(`WINDUP_TICKS`) → STRIKE(`STRIKE_TICKS`) → RECOVER(`RECOVER_TICKS`) → IDLE.
- `flash_cnt`: decrements on `frame_tick` while nonzero. If a grade-3 accept and a `frame_tick` occur in the same cycle, the reload wins.
- `disp_frame` (2 bits) loads the current `anim_state` register only on `frame_tick`. Sprite frame changes happen only at vblank, so there is no mid-frame tearing.
  - If `frame_tick` coincides with an accept, `disp_frame` takes IDLE(0). The windup frame appears at the next tick.
- Pixel path:
  - `col = drawX - sprite_x` and `row = drawY - sprite_y`, computed as 10-bit modular subtraction.
  - `in_box = (col < 64) & (row < 64)`. The wrap makes pixels left of or above the sprite fall outside the box.
  - `rom_addr = {disp_frame, row[5:0], col[5:0]}`, combinational.
- Colour index:
  - `in_box` is registered one cycle to align with `rom_data`.
  - Opaque means `in_box_d1 & (rom_data != 0)`; index 0 is transparent.
  - The registered outputs `pal_index` and `pix_active` get:
    - `pix_active = opaque`
    - `pal_index = !opaque ? 0 : (flash_cnt != 0 ? FLASH_INDEX : rom_data)`
- Reset (any cycle, including mid-animation) sets the following to 0 on the next edge:
  - state = IDLE, `cnt`, `flash_cnt`, `disp_frame`
  - `in_box_d1`, `pal_index`, `pix_active`
  - `anim_state`, `busy`

## Timing
- Accept at edge k: `anim_state` = WINDUP and `busy` = 1 after edge k, and `hit_ready` = 0 from then.
- State dwell is exactly N `frame_tick` pulses after entry, excluding any tick coincident with the entry edge.
- Total animation: `WINDUP_TICKS + STRIKE_TICKS + RECOVER_TICKS` ticks. `hit_ready` returns high the cycle after the last RECOVER tick.
- Pixel latency: `drawX`/`drawY` at cycle t → `rom_addr` at t → `rom_data` at t+1 → `pal_index`/`pix_active` valid after edge t+1, i.e. 2-cycle latency from coordinate.
- `flash_cnt` cleared at tick edge j → override stops for pixels registered after edge j.

## Test plan
- Reset, then grade 2 accept, then 14 `frame_tick` pulses. Required:
  - `anim_state` sequence 1,2,3,0 with switches after ticks 4, 10 and 14.
  - `hit_ready` = 0 throughout and back to 1 after tick 14.
  - `disp_frame` lags `anim_state` by one tick.
- Grade 0 accept → `hit_ready` stays 1, `anim_state` stays 0, no flash. A second `hit_valid` on the next cycle is accepted.
- Grade 3 accept, ROM returns 4'h7 for an in-box opaque pixel → `pal_index` = 4'hD and `pix_active` = 1 for 3 ticks, then `pal_index` = 4'h7. ROM returning 0 gives `pix_active` = 0 and `pal_index` = 0.
- Sprite at (100,50), `drawX` sweep 99..164 on row 50 → `pix_active` may be high only for `drawX` 100..163 (ROM nonzero), observed 2 cycles later. `drawX` = 99 yields col 1023, which is out of box.
- `frame_tick` coincident with accept → `disp_frame` = 0 after that edge and 1 after the next tick.
- Assert `Reset` in STRIKE with flash active → next edge shows `anim_state` = 0, `pal_index` = 0, `pix_active` = 0, `hit_ready` = 1 one cycle after deassert.

Source files
------------

// File: rtl/punch_anim_ctrl.sv
// Punch sprite sequencer: accepts judged hits, walks idle/windup/strike/recover
// on frame ticks, addresses the sprite ROM and produces a registered palette
// index stream with a flash override after perfect hits.
module punch_anim_ctrl #(
  parameter int unsigned WINDUP_TICKS  = 4,
  parameter int unsigned STRIKE_TICKS  = 6,
  parameter int unsigned RECOVER_TICKS = 4,
  parameter int unsigned FLASH_TICKS   = 3,
  parameter logic [3:0]  FLASH_INDEX   = 4'hD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        hit_valid,
  input  logic [1:0]  hit_grade,
  output logic        hit_ready,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  output logic [13:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [3:0]  pal_index,
  output logic        pix_active,
  output logic [1:0]  anim_state,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWindup  = 2'd1,
    StStrike  = 2'd2,
    StRecover = 2'd3
  } state_e;

  localparam logic [7:0] WindupLast  = 8'(WINDUP_TICKS - 1);
  localparam logic [7:0] StrikeLast  = 8'(STRIKE_TICKS - 1);
  localparam logic [7:0] RecoverLast = 8'(RECOVER_TICKS - 1);
  localparam logic [7:0] FlashLoad   = 8'(FLASH_TICKS);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] flash_q, flash_d;
  logic [1:0] disp_q, disp_d;
  logic       accept;
  logic       cnt_last;

  logic [9:0] col, row;
  logic       in_box, in_box_q;
  logic       opaque;
  logic [3:0] pal_d;

  assign hit_ready  = (state_q == StIdle) & ~Reset;
  assign accept     = hit_valid & hit_ready;
  assign anim_state = state_q;
  assign busy       = (state_q != StIdle);

  // Next-state logic for the animation FSM, tick counter, flash and display frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flash_d  = flash_q;
    disp_d   = disp_q;
    cnt_last = 1'b0;

    unique case (state_q)
      StIdle:    cnt_last = 1'b0;
      StWindup:  cnt_last = (cnt_q == WindupLast);
      StStrike:  cnt_last = (cnt_q == StrikeLast);
      StRecover: cnt_last = (cnt_q == RecoverLast);
      default:   cnt_last = 1'b0;
    endcase

    if (state_q == StIdle) begin
      if (accept && hit_grade != 2'd0) begin
        state_d = StWindup;
        cnt_d   = 8'd0;
      end
    end else if (frame_tick) begin
      if (cnt_last) begin
        cnt_d = 8'd0;
        unique case (state_q)
          StWindup:  state_d = StStrike;
          StStrike:  state_d = StRecover;
          StRecover: state_d = StIdle;
          default:   state_d = StIdle;
        endcase
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    // A perfect-hit reload takes priority over a coincident tick decrement.
    if (accept && hit_grade == 2'd3) begin
      flash_d = FlashLoad;
    end else if (frame_tick && flash_q != 8'd0) begin
      flash_d = flash_q - 8'd1;
    end

    // Sprite frame only changes at vblank to avoid tearing.
    if (frame_tick) begin
      disp_d = state_q;
    end
  end

  // Control state registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      flash_q <= 8'd0;
      disp_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      disp_q  <= disp_d;
    end
  end

  // Modular subtraction: pixels left of / above the sprite wrap to large values.
  always_comb begin
    col      = drawX - sprite_x;
    row      = drawY - sprite_y;
    in_box   = (col < 10'd64) & (row < 10'd64);
    rom_addr = {disp_q, row[5:0], col[5:0]};
    opaque   = in_box_q & (rom_data != 4'd0);
    pal_d    = 4'd0;
    if (opaque) begin
      pal_d = (flash_q != 8'd0) ? FLASH_INDEX : rom_data;
    end
  end

  // Pixel pipeline aligned with the one-cycle ROM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_box_q   <= 1'b0;
      pal_index  <= 4'd0;
      pix_active <= 1'b0;
    end else begin
      in_box_q   <= in_box;
      pal_index  <= pal_d;
      pix_active <= opaque;
    end
  end

endmodule

// File: tb/tb_punch_anim_ctrl.sv
// Directed bench for punch_anim_ctrl with a registered constant-fill ROM model.
module tb_punch_anim_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic        hit_valid;
  logic [1:0]  hit_grade;
  logic        hit_ready;
  logic [9:0]  drawX, drawY, sprite_x, sprite_y;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  pal_index;
  logic        pix_active;
  logic [1:0]  anim_state;
  logic        busy;

  logic [3:0]  rom_fill;
  int          vec = 0;
  int          errs = 0;

  punch_anim_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .hit_valid  (hit_valid),
    .hit_grade  (hit_grade),
    .hit_ready  (hit_ready),
    .drawX      (drawX),
    .drawY      (drawY),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pal_index  (pal_index),
    .pix_active (pix_active),
    .anim_state (anim_state),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: data for an address appears one cycle later.
  always @(posedge Clk) rom_data <= rom_fill;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      step();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    vec++;
    if (anim_state !== 2'd0) begin
      errs++; $display("FAIL reset_state got %0d want 0", anim_state);
    end
    vec++;
    if (busy !== 1'b0 || pix_active !== 1'b0 || pal_index !== 4'd0) begin
      errs++; $display("FAIL reset_outs busy=%b pix=%b pal=%h want 0/0/0", busy, pix_active, pal_index);
    end
    vec++;
    if (hit_ready !== 1'b0) begin
      errs++; $display("FAIL reset_ready_in_reset got %b want 0", hit_ready);
    end
    Reset = 1'b0;
    #1;
    vec++;
    if (hit_ready !== 1'b1) begin
      errs++; $display("FAIL reset_ready_after got %b want 1", hit_ready);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] exp_st, prev_st;
    sprite_x = 10'd0; sprite_y = 10'd0; drawX = 10'd5; drawY = 10'd3;
    hit_valid = 1'b1; hit_grade = 2'd2;
    step();
    hit_valid = 1'b0;
    vec++;
    if (anim_state !== 2'd1 || busy !== 1'b1 || hit_ready !== 1'b0) begin
      errs++; $display("FAIL seq_accept st=%0d busy=%b rdy=%b want 1/1/0", anim_state, busy, hit_ready);
    end
    vec++;
    if (rom_addr !== {2'd0, 6'd3, 6'd5}) begin
      errs++; $display("FAIL seq_addr0 got %h want %h", rom_addr, {2'd0, 6'd3, 6'd5});
    end
    prev_st = 2'd1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      exp_st = (i < 4) ? 2'd1 : (i < 10) ? 2'd2 : (i < 14) ? 2'd3 : 2'd0;
      vec++;
      if (anim_state !== exp_st) begin
        errs++; $display("FAIL seq_state tick %0d got %0d want %0d", i, anim_state, exp_st);
      end
      vec++;
      if (hit_ready !== (i == 14)) begin
        errs++; $display("FAIL seq_ready tick %0d got %b want %b", i, hit_ready, (i == 14));
      end
      vec++;
      if (rom_addr !== {prev_st, 6'd3, 6'd5}) begin
        errs++; $display("FAIL seq_disp tick %0d got %h want %h", i, rom_addr, {prev_st, 6'd3, 6'd5});
      end
      prev_st = exp_st;
      step();
    end
  endtask

  task automatic test_grade0();
    rom_fill = 4'h7;
    step();
    step();
    hit_valid = 1'b1; hit_grade = 2'd0;
    step();
    vec++;
    if (anim_state !== 2'd0 || hit_ready !== 1'b1) begin
      errs++; $display("FAIL g0_noop st=%0d rdy=%b want 0/1", anim_state, hit_ready);
    end
    hit_grade = 2'd1;
    step();
    hit_valid = 1'b0;
    vec++;
    if (anim_state !== 2'd1) begin
      errs++; $display("FAIL g0_second_accept st=%0d want 1", anim_state);
    end
    step();
    vec++;
    if (pal_index !== 4'h7 || pix_active !== 1'b1) begin
      errs++; $display("FAIL g0_no_flash pal=%h pix=%b want 7/1", pal_index, pix_active);
    end
    run_ticks(14);
    vec++;
    if (anim_state !== 2'd0) begin
      errs++; $display("FAIL g0_return st=%0d want 0", anim_state);
    end
  endtask

  task automatic test_flash();
    logic [3:0] exp_pal;
    rom_fill = 4'h7;
    hit_valid = 1'b1; hit_grade = 2'd3;
    step();
    hit_valid = 1'b0;
    step();
    vec++;
    if (pal_index !== 4'hD || pix_active !== 1'b1) begin
      errs++; $display("FAIL flash_on pal=%h pix=%b want d/1", pal_index, pix_active);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      step();
      exp_pal = (i < 3) ? 4'hD : 4'h7;
      vec++;
      if (pal_index !== exp_pal) begin
        errs++; $display("FAIL flash_tick %0d pal=%h want %h", i, pal_index, exp_pal);
      end
    end
    rom_fill = 4'h0;
    step();
    step();
    vec++;
    if (pal_index !== 4'h0 || pix_active !== 1'b0) begin
      errs++; $display("FAIL flash_transparent pal=%h pix=%b want 0/0", pal_index, pix_active);
    end
    run_ticks(11);
    vec++;
    if (anim_state !== 2'd0) begin
      errs++; $display("FAIL flash_return st=%0d want 0", anim_state);
    end
  endtask

  task automatic test_sweep();
    logic exp_pix;
    logic [9:0] prev_x;
    sprite_x = 10'd100; sprite_y = 10'd50; drawY = 10'd50; rom_fill = 4'h5;
    prev_x = 10'd0;
    for (int x = 99; x <= 164; x++) begin
      drawX = 10'(x);
      step();
      if (x > 99) begin
        exp_pix = (prev_x >= 10'd100) && (prev_x <= 10'd163);
        vec++;
        if (pix_active !== exp_pix || pal_index !== (exp_pix ? 4'h5 : 4'h0)) begin
          errs++; $display("FAIL sweep x=%0d pix=%b pal=%h want %b", prev_x, pix_active, pal_index, exp_pix);
        end
      end
      prev_x = drawX;
    end
    step();
    vec++;
    if (pix_active !== 1'b0) begin
      errs++; $display("FAIL sweep x=164 pix=%b want 0", pix_active);
    end
    drawX = 10'd120; drawY = 10'd49;
    step(); step();
    vec++;
    if (pix_active !== 1'b0) begin
      errs++; $display("FAIL row_above pix=%b want 0", pix_active);
    end
    drawY = 10'd113;
    step(); step();
    vec++;
    if (pix_active !== 1'b1) begin
      errs++; $display("FAIL row_last pix=%b want 1", pix_active);
    end
    drawY = 10'd114;
    step(); step();
    vec++;
    if (pix_active !== 1'b0) begin
      errs++; $display("FAIL row_below pix=%b want 0", pix_active);
    end
  endtask

  task automatic test_tick_accept();
    sprite_x = 10'd0; sprite_y = 10'd0; drawX = 10'd5; drawY = 10'd3;
    // Earlier tests left the display frame at RECOVER; one idle tick resets it.
    tick();
    step();
    hit_valid = 1'b1; hit_grade = 2'd1; frame_tick = 1'b1;
    step();
    hit_valid = 1'b0; frame_tick = 1'b0;
    vec++;
    if (anim_state !== 2'd1 || rom_addr[13:12] !== 2'd0) begin
      errs++; $display("FAIL tick_accept st=%0d disp=%0d want 1/0", anim_state, rom_addr[13:12]);
    end
    tick();
    vec++;
    if (rom_addr[13:12] !== 2'd1) begin
      errs++; $display("FAIL tick_accept_next disp=%0d want 1", rom_addr[13:12]);
    end
    step();
    run_ticks(13);
    vec++;
    if (anim_state !== 2'd0) begin
      errs++; $display("FAIL tick_accept_return st=%0d want 0", anim_state);
    end
  endtask

  task automatic test_reset_mid();
    rom_fill = 4'h7;
    hit_valid = 1'b1; hit_grade = 2'd3;
    step();
    hit_valid = 1'b0;
    run_ticks(1);
    Reset = 1'b1;
    step();
    vec++;
    if (anim_state !== 2'd0 || pal_index !== 4'h0 || pix_active !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rst_flash st=%0d pal=%h pix=%b busy=%b want 0", anim_state, pal_index, pix_active, busy);
    end
    Reset = 1'b0;
    step();
    vec++;
    if (hit_ready !== 1'b1) begin
      errs++; $display("FAIL rst_flash_ready got %b want 1", hit_ready);
    end
    step();
    vec++;
    if (pal_index !== 4'h7) begin
      errs++; $display("FAIL rst_flash_cleared pal=%h want 7", pal_index);
    end
    hit_valid = 1'b1; hit_grade = 2'd2;
    step();
    hit_valid = 1'b0;
    run_ticks(5);
    vec++;
    if (anim_state !== 2'd2) begin
      errs++; $display("FAIL rst_pre_strike st=%0d want 2", anim_state);
    end
    Reset = 1'b1;
    step();
    vec++;
    if (anim_state !== 2'd0 || pal_index !== 4'h0 || pix_active !== 1'b0) begin
      errs++; $display("FAIL rst_strike st=%0d pal=%h pix=%b want 0", anim_state, pal_index, pix_active);
    end
    Reset = 1'b0;
    step();
    vec++;
    if (hit_ready !== 1'b1 || rom_addr[13:12] !== 2'd0) begin
      errs++; $display("FAIL rst_strike_after rdy=%b disp=%0d want 1/0", hit_ready, rom_addr[13:12]);
    end
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; hit_valid = 1'b0; hit_grade = 2'd0;
    drawX = 10'd0; drawY = 10'd0; sprite_x = 10'd0; sprite_y = 10'd0; rom_fill = 4'h0;
    test_reset();
    test_sequence();
    test_grade0();
    test_flash();
    test_sweep();
    test_tick_accept();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
